// File: rtl/axi_bw_meter_pkg.sv
// Shared widths, channel/struct types and the saturating-increment helper
// used by the AXI bandwidth meter and its in-flight counters.
package axi_bw_meter_pkg;

  localparam int unsigned AxiIdWidthDef    = 4;
  localparam int unsigned CntWidthDef      = 32;
  localparam int unsigned InFlightWidthDef = 16;
  localparam int unsigned SatWidth         = 64;
  localparam int unsigned NumCnt           = 5;

  typedef enum logic [2:0] {
    CntCycles = 3'd0,
    CntAr     = 3'd1,
    CntAw     = 3'd2,
    CntR      = 3'd3,
    CntW      = 3'd4
  } bw_cnt_sel_e;

  typedef struct packed {
    logic [CntWidthDef-1:0] cycles;
    logic [CntWidthDef-1:0] ar;
    logic [CntWidthDef-1:0] aw;
    logic [CntWidthDef-1:0] r;
    logic [CntWidthDef-1:0] w;
  } bw_cnt_t;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0] id;
    logic [31:0]              addr;
    logic [7:0]               len;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0] id;
    logic [31:0]              data;
    logic [1:0]               resp;
    logic                     last;
  } axi_r_chan_t;

  typedef struct packed {
    logic [AxiIdWidthDef-1:0] id;
    logic [1:0]               resp;
  } axi_b_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  // Increment val by one unless it already sits at the all-ones value of 'width' bits.
  function automatic logic [SatWidth-1:0] sat_inc(input logic [SatWidth-1:0] val,
                                                  input logic                inc,
                                                  input int unsigned         width);
    logic [SatWidth-1:0] max_v;
    max_v = (width >= SatWidth) ? {SatWidth{1'b1}}
                                : ((SatWidth'(1) << width) - SatWidth'(1));
    if (inc && (val < max_v)) begin
      sat_inc = val + SatWidth'(1);
    end else begin
      sat_inc = val;
    end
  endfunction

endpackage

// File: rtl/axi_bw_inflight_ctr.sv
// Up/down occupancy counter: simultaneous inc/dec cancel, and a step that would
// underflow or overflow is refused and reported as a one-cycle error pulse.
module axi_bw_inflight_ctr
  import axi_bw_meter_pkg::*;
#(
  parameter int unsigned Width = InFlightWidthDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_r;
  logic [Width-1:0] cnt_next_s;
  logic             err_s;

  // Next count with zero/max guard.
  always_comb begin
    cnt_next_s = cnt_r;
    err_s      = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_r == {Width{1'b1}}) begin
          err_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + Width'(1);
        end
      end
      2'b01: begin
        if (cnt_r == {Width{1'b0}}) begin
          err_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r - Width'(1);
        end
      end
      default: begin
        cnt_next_s = cnt_r;
      end
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {Width{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt_o = cnt_r;
  assign err_o = err_s;

endmodule

// File: rtl/axi_bw_meter.sv
// Passive AXI4 bandwidth/occupancy monitor with saturating activity counters and
// total/per-ID in-flight tracking. Define AXI_BW_METER_REPORT_EN for an end-of-run print.
module axi_bw_meter
  import axi_bw_meter_pkg::*;
#(
  parameter type         req_t         = axi_req_t,
  parameter type         rsp_t         = axi_rsp_t,
  parameter int unsigned AxiIdWidth    = AxiIdWidthDef,
  parameter int unsigned CntWidth      = CntWidthDef,
  parameter int unsigned InFlightWidth = InFlightWidthDef,
  parameter              Name          = "axi_bw_meter"
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     end_of_sim_i,
  input  req_t                     req_i,
  input  rsp_t                     rsp_i,
  output logic [InFlightWidth-1:0] ar_in_flight_o,
  output logic [InFlightWidth-1:0] aw_in_flight_o,
  output logic [CntWidth-1:0]      active_cycles_o,
  output logic [CntWidth-1:0]      ar_cnt_o,
  output logic [CntWidth-1:0]      aw_cnt_o,
  output logic [CntWidth-1:0]      r_beats_o,
  output logic [CntWidth-1:0]      w_beats_o,
  output logic                     err_o
);

  localparam int unsigned NumIds = 2 ** AxiIdWidth;

  logic ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, rl_hs_s, b_hs_s;
  logic frozen_r, err_r, count_s, track_s, err_any_s;
  logic ar_tot_err_s, aw_tot_err_s;
  logic [NumCnt-1:0][CntWidth-1:0] cnt_r, cnt_next_s;
  logic [NumCnt-1:0]               cnt_inc_s;
  logic [AxiIdWidth-1:0]           ar_id_s, aw_id_s, r_id_s, b_id_s;
  logic [NumIds-1:0]               rd_inc_s, rd_dec_s, wr_inc_s, wr_dec_s;
  logic [NumIds-1:0]               rd_err_s, wr_err_s;
  logic [NumIds-1:0][InFlightWidth-1:0] unused_rd_cnt_s, unused_wr_cnt_s;
  logic                            unused_s;

  assign ar_hs_s = req_i.ar_valid & rsp_i.ar_ready;
  assign aw_hs_s = req_i.aw_valid & rsp_i.aw_ready;
  assign w_hs_s  = req_i.w_valid  & rsp_i.w_ready;
  assign r_hs_s  = rsp_i.r_valid  & req_i.r_ready;
  assign rl_hs_s = r_hs_s & rsp_i.r.last;
  assign b_hs_s  = rsp_i.b_valid  & req_i.b_ready;

  assign ar_id_s = req_i.ar.id;
  assign aw_id_s = req_i.aw.id;
  assign r_id_s  = rsp_i.r.id;
  assign b_id_s  = rsp_i.b.id;

  // Occupancy keeps tracking while en_i is low so in-flight state never drifts.
  assign count_s   = en_i & ~frozen_r;
  assign track_s   = ~frozen_r;
  assign cnt_inc_s = {w_hs_s, r_hs_s, aw_hs_s, ar_hs_s, 1'b1};

  // Saturating next value for every activity counter.
  always_comb begin
    cnt_next_s = cnt_r;
    for (int i = 0; i < int'(NumCnt); i++) begin
      if (count_s) begin
        cnt_next_s[i] = CntWidth'(sat_inc(SatWidth'(cnt_r[i]), cnt_inc_s[i], CntWidth));
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Route handshakes to the per-ID counters.
  always_comb begin
    rd_inc_s = '0;
    rd_dec_s = '0;
    wr_inc_s = '0;
    wr_dec_s = '0;
    if (track_s) begin
      rd_inc_s[ar_id_s] = ar_hs_s;
      rd_dec_s[r_id_s]  = rl_hs_s;
      wr_inc_s[aw_id_s] = aw_hs_s;
      wr_dec_s[b_id_s]  = b_hs_s;
    end else begin
      rd_inc_s = '0;
      rd_dec_s = '0;
      wr_inc_s = '0;
      wr_dec_s = '0;
    end
  end

  axi_bw_inflight_ctr #(.Width(InFlightWidth)) i_ar_total (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ar_hs_s & track_s),
    .dec_i  (rl_hs_s & track_s),
    .cnt_o  (ar_in_flight_o),
    .err_o  (ar_tot_err_s)
  );

  axi_bw_inflight_ctr #(.Width(InFlightWidth)) i_aw_total (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (aw_hs_s & track_s),
    .dec_i  (b_hs_s & track_s),
    .cnt_o  (aw_in_flight_o),
    .err_o  (aw_tot_err_s)
  );

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    axi_bw_inflight_ctr #(.Width(InFlightWidth)) i_rd (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (rd_inc_s[g]),
      .dec_i  (rd_dec_s[g]),
      .cnt_o  (unused_rd_cnt_s[g]),
      .err_o  (rd_err_s[g])
    );
    axi_bw_inflight_ctr #(.Width(InFlightWidth)) i_wr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (wr_inc_s[g]),
      .dec_i  (wr_dec_s[g]),
      .cnt_o  (unused_wr_cnt_s[g]),
      .err_o  (wr_err_s[g])
    );
  end

  assign err_any_s = (|rd_err_s) | (|wr_err_s) | ar_tot_err_s | aw_tot_err_s;

  // Freeze flag, sticky error and activity counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frozen_r <= 1'b0;
      err_r    <= 1'b0;
      cnt_r    <= '0;
    end else begin
      frozen_r <= frozen_r | end_of_sim_i;
      err_r    <= err_r | err_any_s;
      cnt_r    <= cnt_next_s;
    end
  end

  assign active_cycles_o = cnt_r[CntCycles];
  assign ar_cnt_o        = cnt_r[CntAr];
  assign aw_cnt_o        = cnt_r[CntAw];
  assign r_beats_o       = cnt_r[CntR];
  assign w_beats_o       = cnt_r[CntW];
  assign err_o           = err_r;

  // Payload fields and per-ID counts are observed only through the guards above.
  assign unused_s = ^{req_i, rsp_i, unused_rd_cnt_s, unused_wr_cnt_s, Name};

`ifdef AXI_BW_METER_REPORT_EN
  bit  reported_q;
  real rd_bpc, wr_bpc;

  // Print one summary at the first clock after the meter froze.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reported_q = 1'b0;
    end else if (frozen_r && !reported_q) begin
      if (cnt_r[CntCycles] == '0) begin
        rd_bpc = 0.0;
        wr_bpc = 0.0;
      end else begin
        rd_bpc = real'(cnt_r[CntR]) / real'(cnt_r[CntCycles]);
        wr_bpc = real'(cnt_r[CntW]) / real'(cnt_r[CntCycles]);
      end
      $display("%s: cycles=%0d ar=%0d aw=%0d r_beats=%0d w_beats=%0d rd_bpc=%0.3f wr_bpc=%0.3f err=%0b",
               Name, cnt_r[CntCycles], cnt_r[CntAr], cnt_r[CntAw], cnt_r[CntR], cnt_r[CntW],
               rd_bpc, wr_bpc, err_r);
      reported_q = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_bw_meter.sv
// Bench for axi_bw_meter: a behavioural model queues the expected outputs for each
// driven cycle; they are popped and compared once the registered outputs update.
module tb_axi_bw_meter;
  import axi_bw_meter_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     en = 1'b0;
  logic     eos = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;

  logic [15:0] arif, awif, s_arif, s_awif;
  logic [31:0] cyc, arc, awc, rb, wb;
  logic [3:0]  s_cyc, s_arc, s_awc, s_rb, s_wb;
  logic        err, s_err;

  typedef struct {
    logic [63:0] cyc, arc, awc, rb, wb, wb4;
    logic [15:0] arif, awif;
    logic        err;
  } snap_t;

  snap_t       sb_q[$];
  int          n_pass = 0;
  int          n_checks = 0;

  logic [63:0] m_cyc, m_arc, m_awc, m_rb, m_wb, m_wb4;
  logic [15:0] m_arif, m_awif;
  logic [15:0] m_rd[16];
  logic [15:0] m_wr[16];
  logic        m_err, m_frozen;

  always #5 clk = ~clk;

  axi_bw_meter dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .end_of_sim_i(eos), .req_i(req), .rsp_i(rsp),
    .ar_in_flight_o(arif), .aw_in_flight_o(awif), .active_cycles_o(cyc), .ar_cnt_o(arc),
    .aw_cnt_o(awc), .r_beats_o(rb), .w_beats_o(wb), .err_o(err)
  );

  axi_bw_meter #(.CntWidth(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .end_of_sim_i(eos), .req_i(req), .rsp_i(rsp),
    .ar_in_flight_o(s_arif), .aw_in_flight_o(s_awif), .active_cycles_o(s_cyc), .ar_cnt_o(s_arc),
    .aw_cnt_o(s_awc), .r_beats_o(s_rb), .w_beats_o(s_wb), .err_o(s_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msat(input logic [63:0] v, input logic inc, input int w);
    if (inc && (v < ((64'd1 << w) - 64'd1))) return v + 64'd1;
    return v;
  endfunction

  task automatic idle();
    req = '0;
    rsp = '0;
  endtask

  task automatic model_reset();
    m_cyc = '0; m_arc = '0; m_awc = '0; m_rb = '0; m_wb = '0; m_wb4 = '0;
    m_arif = '0; m_awif = '0; m_err = 1'b0; m_frozen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_rd[i] = '0;
      m_wr[i] = '0;
    end
    sb_q.delete();
  endtask

  // Apply the current inputs to the model and queue the outputs expected after the edge.
  task automatic model_step();
    logic  ar_hs, aw_hs, w_hs, r_hs, rl_hs, b_hs;
    snap_t s;
    ar_hs = req.ar_valid & rsp.ar_ready;
    aw_hs = req.aw_valid & rsp.aw_ready;
    w_hs  = req.w_valid & rsp.w_ready;
    r_hs  = rsp.r_valid & req.r_ready;
    rl_hs = r_hs & rsp.r.last;
    b_hs  = rsp.b_valid & req.b_ready;
    if (en && !m_frozen) begin
      m_cyc = msat(m_cyc, 1'b1, 32);
      m_arc = msat(m_arc, ar_hs, 32);
      m_awc = msat(m_awc, aw_hs, 32);
      m_rb  = msat(m_rb, r_hs, 32);
      m_wb  = msat(m_wb, w_hs, 32);
      m_wb4 = msat(m_wb4, w_hs, 4);
    end
    if (!m_frozen) begin
      if (!(ar_hs && rl_hs && req.ar.id == rsp.r.id)) begin
        if (ar_hs) begin
          if (m_rd[req.ar.id] == 16'hFFFF) m_err = 1'b1; else m_rd[req.ar.id]++;
        end
        if (rl_hs) begin
          if (m_rd[rsp.r.id] == 16'h0000) m_err = 1'b1; else m_rd[rsp.r.id]--;
        end
      end
      if (!(aw_hs && b_hs && req.aw.id == rsp.b.id)) begin
        if (aw_hs) begin
          if (m_wr[req.aw.id] == 16'hFFFF) m_err = 1'b1; else m_wr[req.aw.id]++;
        end
        if (b_hs) begin
          if (m_wr[rsp.b.id] == 16'h0000) m_err = 1'b1; else m_wr[rsp.b.id]--;
        end
      end
      if (ar_hs && !rl_hs) begin
        if (m_arif == 16'hFFFF) m_err = 1'b1; else m_arif++;
      end else if (rl_hs && !ar_hs) begin
        if (m_arif == 16'h0000) m_err = 1'b1; else m_arif--;
      end
      if (aw_hs && !b_hs) begin
        if (m_awif == 16'hFFFF) m_err = 1'b1; else m_awif++;
      end else if (b_hs && !aw_hs) begin
        if (m_awif == 16'h0000) m_err = 1'b1; else m_awif--;
      end
    end
    m_frozen = m_frozen | eos;
    s.cyc = m_cyc; s.arc = m_arc; s.awc = m_awc; s.rb = m_rb; s.wb = m_wb; s.wb4 = m_wb4;
    s.arif = m_arif; s.awif = m_awif; s.err = m_err;
    sb_q.push_back(s);
  endtask

  task automatic step();
    snap_t s;
    model_step();
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check("active_cycles", 64'(cyc), s.cyc);
    check("ar_cnt", 64'(arc), s.arc);
    check("aw_cnt", 64'(awc), s.awc);
    check("r_beats", 64'(rb), s.rb);
    check("w_beats", 64'(wb), s.wb);
    check("ar_in_flight", 64'(arif), 64'(s.arif));
    check("aw_in_flight", 64'(awif), 64'(s.awif));
    check("err", 64'(err), 64'(s.err));
    check("w_beats_sat4", 64'(s_wb), s.wb4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_cycles", 64'(cyc), 64'd0);
    check("rst_ar_cnt", 64'(arc), 64'd0);
    check("rst_aw_cnt", 64'(awc), 64'd0);
    check("rst_r_beats", 64'(rb), 64'd0);
    check("rst_w_beats", 64'(wb), 64'd0);
    check("rst_ar_in_flight", 64'(arif), 64'd0);
    check("rst_aw_in_flight", 64'(awif), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_w_beats_sat4", 64'(s_wb), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    do_reset();
    en = 1'b1;

    // Read burst on ID 3, eight beats with one stall cycle.
    req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd7; rsp.ar_ready = 1'b1;
    step();
    idle(); rsp.r_valid = 1'b1; rsp.r.id = 4'd3;
    step();
    for (int i = 0; i < 8; i++) begin
      idle(); rsp.r_valid = 1'b1; req.r_ready = 1'b1; rsp.r.id = 4'd3; rsp.r.last = (i == 7);
      step();
    end
    idle(); step();

    // Write on ID 0, then same-cycle AW(ID 1) with B(ID 0), then the final B.
    req.aw_valid = 1'b1; req.aw.id = 4'd0; rsp.aw_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      idle(); req.w_valid = 1'b1; rsp.w_ready = 1'b1; req.w.last = (i == 3);
      step();
    end
    idle();
    req.aw_valid = 1'b1; req.aw.id = 4'd1; rsp.aw_ready = 1'b1;
    rsp.b_valid = 1'b1; rsp.b.id = 4'd0; req.b_ready = 1'b1;
    step();
    idle(); rsp.b_valid = 1'b1; rsp.b.id = 4'd1; req.b_ready = 1'b1;
    step();

    // Same-cycle AR and last R on the same idle ID: no change, no error.
    idle();
    req.ar_valid = 1'b1; req.ar.id = 4'd5; rsp.ar_ready = 1'b1;
    rsp.r_valid = 1'b1; req.r_ready = 1'b1; rsp.r.id = 4'd5; rsp.r.last = 1'b1;
    step();

    // Counting disabled for 10 cycles with traffic, then enabled for 20.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(); req.w_valid = 1'b1; rsp.w_ready = 1'b1;
      if (i == 2) begin req.ar_valid = 1'b1; req.ar.id = 4'd6; rsp.ar_ready = 1'b1; end
      if (i == 6) begin rsp.r_valid = 1'b1; req.r_ready = 1'b1; rsp.r.id = 4'd6; rsp.r.last = 1'b1; end
      step();
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i % 3 == 0) begin req.w_valid = 1'b1; rsp.w_ready = 1'b1; end
      step();
    end

    // Twenty more W beats drive the 4-bit instance into saturation.
    for (int i = 0; i < 20; i++) begin
      idle(); req.w_valid = 1'b1; rsp.w_ready = 1'b1;
      step();
    end
    check("w_beats_saturated", 64'(s_wb), 64'd15);

    // Unexpected B on ID 2.
    idle(); rsp.b_valid = 1'b1; rsp.b.id = 4'd2; req.b_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end
    check("err_sticky", 64'(err), 64'd1);

    // Freeze, then keep driving traffic.
    idle(); eos = 1'b1; req.w_valid = 1'b1; rsp.w_ready = 1'b1;
    step();
    eos = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle();
      req.ar_valid = 1'b1; req.ar.id = 4'(i); rsp.ar_ready = 1'b1;
      req.aw_valid = 1'b1; req.aw.id = 4'(i); rsp.aw_ready = 1'b1;
      req.w_valid = 1'b1; rsp.w_ready = 1'b1;
      rsp.b_valid = 1'b1; rsp.b.id = 4'd9; req.b_ready = (i > 4);
      step();
    end

    // Reset with a read outstanding; its late response must flag an error.
    do_reset();
    idle(); req.ar_valid = 1'b1; req.ar.id = 4'd1; rsp.ar_ready = 1'b1;
    step();
    idle();
    do_reset();
    rsp.r_valid = 1'b1; req.r_ready = 1'b1; rsp.r.id = 4'd1; rsp.r.last = 1'b1;
    step();
    idle(); step();
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
